// File: rtl/multiplier_4_pkg.sv
// Shared constants for the sequential Booth multiplier.
// State encodings stay plain localparams so legacy RTL can compare against them directly.
package multiplier_4_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/multiplier_4.sv
// Sequential signed multiplier: radix-2 Booth, one step per clock, nb steps per product.
// A single nb+1-bit adder serves both add and subtract through invert/carry-in.
module multiplier_4
  import multiplier_4_pkg::*;
#(
  parameter int nb = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [nb-1:0]     A,
  input  logic [nb-1:0]     B,
  output logic [2*nb-1:0]   Product,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(nb + 1);
  localparam logic [CW-1:0] LAST = CW'(nb - 1);

  logic [0:0]    state;
  logic [nb-1:0] m;
  logic [nb-1:0] q;
  logic          q_m1;
  logic [nb:0]   acc;
  logic [CW-1:0] count;

  logic [nb:0]   m_ext;
  logic [nb:0]   addend;
  logic [nb:0]   sum;
  logic          do_op;
  logic          sub;

  // Acc is one bit wider than M so subtracting M = -2^(nb-1) cannot overflow.
  always_comb begin
    m_ext  = {m[nb-1], m};
    do_op  = q[0] ^ q_m1;
    sub    = q[0] & ~q_m1;
    addend = '0;
    if (do_op) begin
      addend = sub ? ~m_ext : m_ext;
    end
    sum = acc + addend + {{nb{1'b0}}, sub};
  end

  assign busy = (state == ST_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      m       <= '0;
      q       <= '0;
      q_m1    <= 1'b0;
      acc     <= '0;
      count   <= '0;
      Product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            m     <= A;
            q     <= B;
            q_m1  <= 1'b0;
            acc   <= '0;
            count <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc   <= {sum[nb], sum[nb:1]};
          q     <= {sum[0], q[nb-1:1]};
          q_m1  <= q[0];
          count <= count + 1'b1;
          // The final product is the post-shift {Acc[nb-1:0], Q}, i.e. {sum, Q[nb-1:1]}.
          if (count == LAST) begin
            Product <= {sum, q[nb-1:1]};
            done    <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_4.sv
// Scoreboard bench for multiplier_4 (nb=32): expected products are queued at start
// and compared when done pulses, alongside timing, hold and reset checks.
module tb_multiplier_4;

  localparam int NB = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [NB-1:0]   A;
  logic [NB-1:0]   B;
  logic [2*NB-1:0] Product;
  logic            busy;
  logic            done;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [63:0] sb[$];
  logic [63:0] last_result = '0;

  multiplier_4 #(.nb(NB)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .Product (Product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Drive a one-cycle start; returns at the falling edge just after the sampling edge E0.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit push);
    @(negedge clk);
    start = 1'b1;
    A = a;
    B = b;
    if (push) sb.push_back(ref_product(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // k_start is how many edges after E0 the caller already is; done must appear after E32.
  task automatic waitResult(input string tag, input int k_start, input bit check_latency);
    int k;
    logic [63:0] exp_val;
    k = k_start;
    while (done !== 1'b1 && k < NB + 4) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    if (check_latency) checkOutput({tag, "_lat"}, 64'(k), 64'd32);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb"}, 64'(sb.size()), 64'd1);
    end else begin
      exp_val = sb.pop_front();
      checkOutput(tag, Product, exp_val);
      last_result = exp_val;
    end
    @(negedge clk);
    if (check_latency) begin
      checkOutput({tag, "_done_drop"}, 64'(done), 64'd0);
      checkOutput({tag, "_busy_drop"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_product", Product, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Basic sign cases, with busy visible right after the start edge.
    applyStimulus(32'd3, 32'd5, 1'b1);
    checkOutput("busy_e0", 64'(busy), 64'd1);
    waitResult("p3x5", 0, 1'b1);
    checkOutput("p3x5_const", last_result, 64'h0000_0000_0000_000F);
    applyStimulus(-32'sd3, 32'd5, 1'b1);
    waitResult("m3x5", 0, 1'b1);
    checkOutput("m3x5_const", Product, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus(-32'sd3, -32'sd5, 1'b1);
    waitResult("m3xm5", 0, 1'b1);

    // Extremes.
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
    waitResult("min_x_min", 0, 1'b1);
    checkOutput("min_x_min_const", Product, 64'h4000_0000_0000_0000);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    waitResult("max_x_min", 0, 1'b1);
    checkOutput("max_x_min_const", Product, 64'hC000_0000_8000_0000);
    applyStimulus(32'h0, 32'hFFFF_FFFF, 1'b1);
    waitResult("zero", 0, 1'b1);

    // Operands scrambled after capture must not affect the result.
    applyStimulus(32'd12345, -32'sd678, 1'b1);
    for (int i = 0; i < 10; i++) begin
      A = $urandom;
      B = $urandom;
      @(negedge clk);
    end
    waitResult("capture", 10, 1'b1);

    // Start while busy is ignored; old Product holds through the iteration.
    applyStimulus(32'd6, 32'd7, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    A = 32'd100;
    B = 32'd100;
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_product", Product, last_result);
    checkOutput("hold_busy", 64'(busy), 64'd1);
    waitResult("busy_ignore", 5, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("no_restart_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation discards the partial result.
    applyStimulus(32'd11, 32'd13, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("pre_rst_product", Product, last_result);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_product", Product, 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'd7, -32'sd9, 1'b1);
    waitResult("after_rst", 0, 1'b1);
    checkOutput("after_rst_const", Product, 64'hFFFF_FFFF_FFFF_FFC1);

    // Random regression against the 64-bit signed reference.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus($urandom, $urandom, 1'b1);
      waitResult("random", 0, 1'b0);
    end

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
